l2_per_bridge_fsm: RTL and testbench

Peripheral-side bridge sitting directly downstream of the L2 TCDM demux's bridge (PER) port. It decodes each granted request onto one of N_PERIPHS peripheral master ports and tracks the single outstanding transaction. It returns the response with the captured AUX tag. It synthesises error responses for decode misses and for response timeouts, and discards late responses from timed-out peripherals.

---
 rtl/l2_per_bridge_fsm.sv | 228 ++++++++++++++++++++++
 tb/tb_l2_per_bridge_fsm.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_per_bridge_fsm.sv
// ---------------------------------------------------------------------------
// l2_per_bridge_fsm
//
// Peripheral-side bridge behind the L2 TCDM demux PER port. Each upstream
// request is decoded onto one of N_PERIPHS peripheral master ports, and the
// single outstanding transaction is tracked until it completes. The response
// carries the AUX tag captured when the request was granted. Decode misses
// and response timeouts produce a synthesised error response
// (opc=1, rdata=0xBADACCE5). A late response from a timed-out peripheral is
// swallowed, and that peripheral is blocked until its late response arrives.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   data_req_i .. data_aux_i     upstream request
//   data_gnt_o                   upstream grant (combinational)
//   data_r_valid_o/_rdata_o/
//   data_r_opc_o/_aux_o          upstream response (opc=1 -> error)
//   per_req_o                    one-hot request per peripheral
//   per_add_o/_wen_o/_wdata_o/
//   per_be_o                     request fields broadcast to all peripherals
//   per_gnt_i                    per-peripheral grant
//   per_r_valid_i/_opc_i/_rdata_i per-peripheral response (rdata packed)
//   PER_START_ADDR/PER_END_ADDR  packed decode windows [start, end)
//   dbg_state_o                  current FSM state (0 idle, 1 wait, 2 error)
//
// Handshake: a request transfers in the cycle data_req_i && data_gnt_o;
// a response transfers in the cycle data_r_valid_o (no upstream back-pressure).
// ---------------------------------------------------------------------------
module l2_per_bridge_fsm #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = DATA_WIDTH/8,
  parameter int AUX_WIDTH      = 4,
  parameter int N_PERIPHS      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            data_req_i,
  input  logic [ADDR_WIDTH-1:0]           data_add_i,
  input  logic                            data_wen_i,
  input  logic [DATA_WIDTH-1:0]           data_wdata_i,
  input  logic [BE_WIDTH-1:0]             data_be_i,
  input  logic [AUX_WIDTH-1:0]            data_aux_i,
  output logic                            data_gnt_o,
  output logic                            data_r_valid_o,
  output logic [DATA_WIDTH-1:0]           data_r_rdata_o,
  output logic                            data_r_opc_o,
  output logic [AUX_WIDTH-1:0]            data_r_aux_o,
  output logic [N_PERIPHS-1:0]            per_req_o,
  output logic [ADDR_WIDTH-1:0]           per_add_o,
  output logic                            per_wen_o,
  output logic [DATA_WIDTH-1:0]           per_wdata_o,
  output logic [BE_WIDTH-1:0]             per_be_o,
  input  logic [N_PERIPHS-1:0]            per_gnt_i,
  input  logic [N_PERIPHS-1:0]            per_r_valid_i,
  input  logic [N_PERIPHS-1:0]            per_r_opc_i,
  input  logic [N_PERIPHS*DATA_WIDTH-1:0] per_r_rdata_i,
  input  logic [N_PERIPHS*ADDR_WIDTH-1:0] PER_START_ADDR,
  input  logic [N_PERIPHS*ADDR_WIDTH-1:0] PER_END_ADDR,
  output logic [1:0]                      dbg_state_o
);

  localparam int SEL_W = $clog2(N_PERIPHS);
  // Keep the counter at least one bit wide so TIMEOUT_CYCLES=0 still elaborates.
  localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam int ERR_W = (DATA_WIDTH < 32) ? DATA_WIDTH : 32;
  localparam logic [31:0] ERR_WORD = 32'hBADACCE5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q;
  logic [AUX_WIDTH-1:0]   aux_q;
  logic [TMO_W-1:0]       tmo_cnt;
  logic [N_PERIPHS-1:0]   discard_q;

  logic                   hit;
  logic [SEL_W-1:0]       hit_idx;
  logic                   sel_valid;
  logic                   sel_opc;
  logic [DATA_WIDTH-1:0]  sel_rdata;
  logic [DATA_WIDTH-1:0]  err_data;
  logic                   in_window;
  logic                   fwd_req;
  logic                   take;
  logic                   miss_take;
  logic                   tmo_hit;

  // Address decode; descending scan so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int p = N_PERIPHS - 1; p >= 0; p--) begin
      if (data_add_i >= PER_START_ADDR[p*ADDR_WIDTH +: ADDR_WIDTH] &&
          data_add_i <  PER_END_ADDR[p*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(p);
      end
    end
  end

  assign sel_valid = per_r_valid_i[sel_q];
  assign sel_opc   = per_r_opc_i[sel_q];
  assign sel_rdata = per_r_rdata_i[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    err_data            = '0;
    err_data[ERR_W-1:0] = ERR_WORD[ERR_W-1:0];
  end

  // A new request may be taken when idle, or in the cycle the outstanding
  // peripheral answers (back-to-back). Reset closes the window.
  assign in_window = !rst && ((state_q == S_IDLE) || (state_q == S_WAIT && sel_valid));
  // discard_q is the registered value: a late response clearing it this
  // cycle still stalls the request until the next cycle.
  assign fwd_req   = in_window && data_req_i && hit && !discard_q[hit_idx];
  assign take      = fwd_req && per_gnt_i[hit_idx];
  assign miss_take = in_window && data_req_i && !hit;
  assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (state_q == S_WAIT) && !sel_valid &&
                     (tmo_cnt == TMO_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Transaction bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q     <= '0;
      aux_q     <= '0;
      tmo_cnt   <= '0;
      discard_q <= '0;
    end else begin
      if (take) begin
        sel_q   <= hit_idx;
        aux_q   <= data_aux_i;
        tmo_cnt <= '0;
      end else begin
        if (miss_take) begin
          aux_q <= data_aux_i;
        end
        if (state_q == S_WAIT && !sel_valid) begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end
      for (int p = 0; p < N_PERIPHS; p++) begin
        if (per_r_valid_i[p] && discard_q[p]) begin
          discard_q[p] <= 1'b0;
        end
      end
      // The timed-out peripheral has not answered this cycle, so this never
      // collides with the clear above.
      if (tmo_hit) begin
        discard_q[sel_q] <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (miss_take)  state_d = S_ERROR;
        else if (take)  state_d = S_WAIT;
        else            state_d = S_IDLE;
      end
      S_WAIT: begin
        if (miss_take)      state_d = S_ERROR;
        else if (take)      state_d = S_WAIT;
        else if (sel_valid) state_d = S_IDLE;
        else if (tmo_hit)   state_d = S_ERROR;
        else                state_d = S_WAIT;
      end
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    per_req_o      = '0;
    data_gnt_o     = take || miss_take;
    data_r_valid_o = 1'b0;
    data_r_opc_o   = 1'b0;
    data_r_rdata_o = '0;
    data_r_aux_o   = aux_q;
    if (fwd_req) begin
      per_req_o[hit_idx] = 1'b1;
    end
    if (rst) begin
      data_r_aux_o = '0;
    end else begin
      unique case (state_q)
        S_WAIT: begin
          data_r_valid_o = sel_valid;
          data_r_opc_o   = sel_opc;
          data_r_rdata_o = sel_rdata;
        end
        S_ERROR: begin
          data_r_valid_o = 1'b1;
          data_r_opc_o   = 1'b1;
          data_r_rdata_o = err_data;
        end
        default: ;
      endcase
    end
  end

  assign per_add_o   = data_add_i;
  assign per_wen_o   = data_wen_i;
  assign per_wdata_o = data_wdata_i;
  assign per_be_o    = data_be_i;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_l2_per_bridge_fsm.sv
// ---------------------------------------------------------------------------
// tb_l2_per_bridge_fsm
//
// Bench for l2_per_bridge_fsm with 4 peripherals and a 4-cycle timeout.
// Windows: p0 [0x0000,0x1000), p1 [0x0800,0x2000) (overlaps p0),
//          p2 [0x2000,0x3000), p3 [0x3000,0x4000); 0x8000 misses.
// Inputs change 1ns after the rising edge; outputs are sampled on the
// falling edge. Expected responses {aux, opc, rdata} are queued when the
// request is granted and popped by a response monitor.
// ---------------------------------------------------------------------------
module tb_l2_per_bridge_fsm;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int XW = 4;
  localparam int NP = 4;
  localparam int RW = XW + 1 + DW;
  localparam logic [DW-1:0] ERR = 32'hBADACCE5;

  logic              clk = 1'b0;
  logic              rst;
  logic              data_req_i;
  logic [AW-1:0]     data_add_i;
  logic              data_wen_i;
  logic [DW-1:0]     data_wdata_i;
  logic [BW-1:0]     data_be_i;
  logic [XW-1:0]     data_aux_i;
  logic              data_gnt_o;
  logic              data_r_valid_o;
  logic [DW-1:0]     data_r_rdata_o;
  logic              data_r_opc_o;
  logic [XW-1:0]     data_r_aux_o;
  logic [NP-1:0]     per_req_o;
  logic [AW-1:0]     per_add_o;
  logic              per_wen_o;
  logic [DW-1:0]     per_wdata_o;
  logic [BW-1:0]     per_be_o;
  logic [NP-1:0]     per_gnt_i;
  logic [NP-1:0]     per_r_valid_i;
  logic [NP-1:0]     per_r_opc_i;
  logic [NP*DW-1:0]  per_r_rdata_i;
  logic [NP*AW-1:0]  per_start_addr;
  logic [NP*AW-1:0]  per_end_addr;
  logic [1:0]        dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [RW-1:0] exp_q[$];

  l2_per_bridge_fsm #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .AUX_WIDTH(XW),
    .N_PERIPHS(NP), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_aux_i(data_aux_i),
    .data_gnt_o(data_gnt_o),
    .data_r_valid_o(data_r_valid_o), .data_r_rdata_o(data_r_rdata_o),
    .data_r_opc_o(data_r_opc_o), .data_r_aux_o(data_r_aux_o),
    .per_req_o(per_req_o), .per_add_o(per_add_o), .per_wen_o(per_wen_o),
    .per_wdata_o(per_wdata_o), .per_be_o(per_be_o),
    .per_gnt_i(per_gnt_i), .per_r_valid_i(per_r_valid_i),
    .per_r_opc_i(per_r_opc_i), .per_r_rdata_i(per_r_rdata_i),
    .PER_START_ADDR(per_start_addr), .PER_END_ADDR(per_end_addr),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    data_req_i    = 1'b0;
    data_add_i    = '0;
    data_wen_i    = 1'b0;
    data_wdata_i  = '0;
    data_be_i     = '0;
    data_aux_i    = '0;
    per_gnt_i     = '0;
    per_r_valid_i = '0;
    per_r_opc_i   = '0;
    per_r_rdata_i = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic drive_req(input logic [AW-1:0] addr, input logic [XW-1:0] aux,
                           input logic [NP-1:0] gnt);
    data_req_i   = 1'b1;
    data_add_i   = addr;
    data_wen_i   = 1'($urandom_range(0, 1));
    data_wdata_i = $urandom;
    data_be_i    = 4'($urandom_range(0, 15));
    data_aux_i   = aux;
    per_gnt_i    = gnt;
  endtask

  // Valid only on peripheral p; every other rdata lane carries junk.
  task automatic drive_rsp(input int p, input logic [DW-1:0] rd, input logic opc);
    per_r_rdata_i = {$urandom, $urandom, $urandom, $urandom};
    per_r_valid_i = '0;
    per_r_opc_i   = '0;
    per_r_valid_i[p] = 1'b1;
    per_r_opc_i[p]   = opc;
    per_r_rdata_i[p*DW +: DW] = rd;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [RW-1:0] got;
    logic [RW-1:0] exp;
    if (data_r_valid_o === 1'b1) begin
      got = {data_r_aux_o, data_r_opc_o, data_r_rdata_o};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got {aux,opc,rdata}=%h, required no response", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL rsp_data: got {aux,opc,rdata}=%h, required %h", got, exp);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    drive_req(32'h1004, 4'h3, 4'hF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (data_gnt_o !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %b, required 0", data_gnt_o); end
    n_checks++; if (per_req_o !== 4'b0000) begin n_fail++; $display("FAIL rst_per_req: got %b, required 0000", per_req_o); end
    n_checks++; if (data_r_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", data_r_valid_o); end
    n_checks++; if (data_r_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h, required 0", data_r_rdata_o); end
    n_checks++; if (data_r_opc_o !== 1'b0) begin n_fail++; $display("FAIL rst_opc: got %b, required 0", data_r_opc_o); end
    n_checks++; if (data_r_aux_o !== 4'h0) begin n_fail++; $display("FAIL rst_aux: got %h, required 0", data_r_aux_o); end
    n_checks++; if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d, required 0", dbg_state_o); end
    n_checks++; if (per_add_o !== 32'h1004) begin n_fail++; $display("FAIL rst_per_add: got %h, required 1004", per_add_o); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    n_checks++; if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL post_rst_state: got %0d, required 0", dbg_state_o); end
    n_checks++; if (data_gnt_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_gnt: got %b, required 0", data_gnt_o); end
  endtask

  task automatic test_read();
    cycle();
    drive_req(32'h1004, 4'h5, 4'b0010);
    @(negedge clk);
    n_checks++; if (per_req_o !== 4'b0010) begin n_fail++; $display("FAIL read_per_req: got %b, required 0010", per_req_o); end
    n_checks++; if (data_gnt_o !== 1'b1) begin n_fail++; $display("FAIL read_gnt: got %b, required 1", data_gnt_o); end
    n_checks++; if (per_add_o !== 32'h1004) begin n_fail++; $display("FAIL read_per_add: got %h, required 1004", per_add_o); end
    n_checks++; if (per_wdata_o !== data_wdata_i || per_be_o !== data_be_i || per_wen_o !== data_wen_i) begin
      n_fail++; $display("FAIL read_broadcast: got wdata=%h be=%h wen=%b, required %h %h %b",
                         per_wdata_o, per_be_o, per_wen_o, data_wdata_i, data_be_i, data_wen_i);
    end
    exp_q.push_back({4'h5, 1'b0, 32'h0000_1234});
    cycle();
    @(negedge clk);
    n_checks++; if (dbg_state_o !== 2'd1) begin n_fail++; $display("FAIL read_wait_state: got %0d, required 1", dbg_state_o); end
    n_checks++; if (data_r_valid_o !== 1'b0) begin n_fail++; $display("FAIL read_early_valid: got %b, required 0", data_r_valid_o); end
    cycle();
    drive_rsp(1, 32'h0000_1234, 1'b0);
    @(negedge clk);
    n_checks++; if (data_r_valid_o !== 1'b1) begin n_fail++; $display("FAIL read_valid: got %b, required 1", data_r_valid_o); end
    cycle();
    @(negedge clk);
    n_checks++; if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL read_idle: got %0d, required 0", dbg_state_o); end
    n_checks++; if (data_r_valid_o !== 1'b0) begin n_fail++; $display("FAIL read_valid_drop: got %b, required 0", data_r_valid_o); end
  endtask

  task automatic test_miss();
    cycle();
    drive_req(32'h8000, 4'hA, 4'hF);
    @(negedge clk);
    n_checks++; if (data_gnt_o !== 1'b1) begin n_fail++; $display("FAIL miss_gnt: got %b, required 1", data_gnt_o); end
    n_checks++; if (per_req_o !== 4'b0000) begin n_fail++; $display("FAIL miss_per_req: got %b, required 0000", per_req_o); end
    exp_q.push_back({4'hA, 1'b1, ERR});
    cycle();
    drive_req(32'h2000, 4'h1, 4'hF);
    @(negedge clk);
    n_checks++; if (data_gnt_o !== 1'b0) begin n_fail++; $display("FAIL err_cycle_gnt: got %b, required 0", data_gnt_o); end
    n_checks++; if (per_req_o !== 4'b0000) begin n_fail++; $display("FAIL err_cycle_per_req: got %b, required 0000", per_req_o); end
    n_checks++; if (dbg_state_o !== 2'd2) begin n_fail++; $display("FAIL err_state: got %0d, required 2", dbg_state_o); end
    n_checks++; if (data_r_valid_o !== 1'b1) begin n_fail++; $display("FAIL err_valid: got %b, required 1", data_r_valid_o); end
    cycle();
    @(negedge clk);
    n_checks++; if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL miss_idle: got %0d, required 0", dbg_state_o); end
  endtask

  task automatic test_back_to_back();
    cycle();
    drive_req(32'h0010, 4'h3, 4'b0001);
    @(negedge clk);
    n_checks++; if (data_gnt_o !== 1'b1 || per_req_o !== 4'b0001) begin
      n_fail++; $display("FAIL b2b_first: got gnt=%b req=%b, required 1 0001", data_gnt_o, per_req_o);
    end
    exp_q.push_back({4'h3, 1'b0, 32'hAAAA_0000});
    cycle();
    drive_req(32'h2010, 4'hC, 4'b0100);
    @(negedge clk);
    n_checks++; if (data_gnt_o !== 1'b0 || per_req_o !== 4'b0000) begin
      n_fail++; $display("FAIL b2b_wait_block: got gnt=%b req=%b, required 0 0000", data_gnt_o, per_req_o);
    end
    cycle();
    drive_req(32'h2010, 4'hC, 4'b0100);
    drive_rsp(0, 32'hAAAA_0000, 1'b0);
    @(negedge clk);
    n_checks++; if (data_gnt_o !== 1'b1 || per_req_o !== 4'b0100) begin
      n_fail++; $display("FAIL b2b_second: got gnt=%b req=%b, required 1 0100", data_gnt_o, per_req_o);
    end
    n_checks++; if (data_r_aux_o !== 4'h3) begin n_fail++; $display("FAIL b2b_old_aux: got %h, required 3", data_r_aux_o); end
    exp_q.push_back({4'hC, 1'b1, 32'h0000_5555});
    cycle();
    drive_rsp(2, 32'h0000_5555, 1'b1);
    @(negedge clk);
    n_checks++; if (data_r_aux_o !== 4'hC) begin n_fail++; $display("FAIL b2b_new_aux: got %h, required C", data_r_aux_o); end
    cycle();
    @(negedge clk);
    n_checks++; if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL b2b_idle: got %0d, required 0", dbg_state_o); end
  endtask

  task automatic test_timeout();
    cycle();
    drive_req(32'h3000, 4'h7, 4'b1000);
    @(negedge clk);
    n_checks++; if (data_gnt_o !== 1'b1) begin n_fail++; $display("FAIL tmo_gnt: got %b, required 1", data_gnt_o); end
    exp_q.push_back({4'h7, 1'b1, ERR});
    for (int k = 1; k <= 3; k++) begin
      cycle();
      @(negedge clk);
      n_checks++; if (dbg_state_o !== 2'd1 || data_r_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL tmo_wait%0d: got state=%0d valid=%b, required 1 0", k, dbg_state_o, data_r_valid_o);
      end
    end
    cycle();
    drive_req(32'h1000, 4'h2, 4'b0010);
    @(negedge clk);
    n_checks++; if (data_gnt_o !== 1'b0 || per_req_o !== 4'b0000 || data_r_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL tmo_cycle: got gnt=%b req=%b valid=%b, required 0 0000 0",
                         data_gnt_o, per_req_o, data_r_valid_o);
    end
    cycle();
    @(negedge clk);
    n_checks++; if (data_r_valid_o !== 1'b1 || dbg_state_o !== 2'd2) begin
      n_fail++; $display("FAIL tmo_err: got valid=%b state=%0d, required 1 2", data_r_valid_o, dbg_state_o);
    end
    for (int k = 0; k < 2; k++) begin
      cycle();
      drive_req(32'h3004, 4'h9, 4'b1000);
      @(negedge clk);
      n_checks++; if (data_gnt_o !== 1'b0 || per_req_o !== 4'b0000) begin
        n_fail++; $display("FAIL tmo_stall%0d: got gnt=%b req=%b, required 0 0000", k, data_gnt_o, per_req_o);
      end
    end
    cycle();
    drive_req(32'h3004, 4'h9, 4'b1000);
    drive_rsp(3, 32'hDEAD_0003, 1'b0);
    @(negedge clk);
    n_checks++; if (data_gnt_o !== 1'b0 || per_req_o !== 4'b0000 || data_r_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL tmo_late: got gnt=%b req=%b valid=%b, required 0 0000 0",
                         data_gnt_o, per_req_o, data_r_valid_o);
    end
    cycle();
    drive_req(32'h3004, 4'h9, 4'b1000);
    @(negedge clk);
    n_checks++; if (data_gnt_o !== 1'b1 || per_req_o !== 4'b1000) begin
      n_fail++; $display("FAIL tmo_release: got gnt=%b req=%b, required 1 1000", data_gnt_o, per_req_o);
    end
    exp_q.push_back({4'h9, 1'b0, 32'h0000_9999});
    cycle();
    drive_rsp(3, 32'h0000_9999, 1'b0);
    @(negedge clk);
    n_checks++; if (data_r_valid_o !== 1'b1) begin n_fail++; $display("FAIL tmo_resp_valid: got %b, required 1", data_r_valid_o); end
    cycle();
    @(negedge clk);
    n_checks++; if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL tmo_idle: got %0d, required 0", dbg_state_o); end
  endtask

  task automatic test_overlap();
    cycle();
    drive_req(32'h0900, 4'h4, 4'b0011);
    @(negedge clk);
    n_checks++; if (per_req_o !== 4'b0001 || data_gnt_o !== 1'b1) begin
      n_fail++; $display("FAIL overlap: got req=%b gnt=%b, required 0001 1", per_req_o, data_gnt_o);
    end
    exp_q.push_back({4'h4, 1'b0, 32'h0009_00AB});
    cycle();
    drive_rsp(0, 32'h0009_00AB, 1'b0);
    cycle();
    drive_req(32'h1800, 4'h6, 4'b0000);
    @(negedge clk);
    n_checks++; if (per_req_o !== 4'b0010 || data_gnt_o !== 1'b0) begin
      n_fail++; $display("FAIL p1_nognt: got req=%b gnt=%b, required 0010 0", per_req_o, data_gnt_o);
    end
    cycle();
    @(negedge clk);
    n_checks++; if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL nognt_idle: got %0d, required 0", dbg_state_o); end
  endtask

  task automatic test_reset_mid();
    // Time out p2 first so reset has a discard flag to clear.
    cycle();
    drive_req(32'h2200, 4'h6, 4'b0100);
    @(negedge clk);
    n_checks++; if (data_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rm_tmo_gnt: got %b, required 1", data_gnt_o); end
    exp_q.push_back({4'h6, 1'b1, ERR});
    repeat (4) cycle();
    cycle();
    @(negedge clk);
    n_checks++; if (data_r_valid_o !== 1'b1) begin n_fail++; $display("FAIL rm_tmo_err: got %b, required 1", data_r_valid_o); end
    cycle();
    drive_req(32'h1008, 4'h2, 4'b0010);
    @(negedge clk);
    n_checks++; if (data_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rm_gnt: got %b, required 1", data_gnt_o); end
    cycle();
    rst = 1'b1;
    drive_req(32'h0000, 4'h3, 4'b0001);
    @(negedge clk);
    n_checks++; if (data_gnt_o !== 1'b0 || per_req_o !== 4'b0000 || data_r_valid_o !== 1'b0 || data_r_aux_o !== 4'h0) begin
      n_fail++; $display("FAIL rm_during: got gnt=%b req=%b valid=%b aux=%h, required 0 0000 0 0",
                         data_gnt_o, per_req_o, data_r_valid_o, data_r_aux_o);
    end
    cycle();
    rst = 1'b0;
    drive_rsp(1, 32'hFEED_0001, 1'b0);
    @(negedge clk);
    n_checks++; if (dbg_state_o !== 2'd0 || data_r_valid_o !== 1'b0 || data_r_aux_o !== 4'h0 || data_r_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL rm_after: got state=%0d valid=%b aux=%h rdata=%h, required 0 0 0 0",
                         dbg_state_o, data_r_valid_o, data_r_aux_o, data_r_rdata_o);
    end
    cycle();
    drive_req(32'h2200, 4'h1, 4'b0100);
    @(negedge clk);
    n_checks++; if (data_gnt_o !== 1'b1 || per_req_o !== 4'b0100) begin
      n_fail++; $display("FAIL rm_discard_clr: got gnt=%b req=%b, required 1 0100", data_gnt_o, per_req_o);
    end
    exp_q.push_back({4'h1, 1'b0, 32'h0000_0077});
    cycle();
    drive_rsp(2, 32'h0000_0077, 1'b0);
    cycle();
    @(negedge clk);
    n_checks++; if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL rm_idle: got %0d, required 0", dbg_state_o); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    per_start_addr = {32'h3000, 32'h2000, 32'h0800, 32'h0000};
    per_end_addr   = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
    test_reset();
    test_read();
    test_miss();
    test_back_to_back();
    test_timeout();
    test_overlap();
    test_reset_mid();
    cycle();
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d responses outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
